// File: rtl/sm_pkg.sv
// Shared types and sign-magnitude ordering helpers for the min/max tracker.
// Helpers take the live width n so one definition serves every sample width.
package sm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned SM_MAX_W = 64;

   typedef logic [SM_MAX_W-1:0] sm_word_t;

   function automatic logic sm_sign(input sm_word_t x, input int unsigned n);
      sm_word_t sh;
      sh = x >> (n - 1);
      return sh[0];
   endfunction

   function automatic sm_word_t sm_mag(input sm_word_t x, input int unsigned n);
      return x & ((SM_MAX_W'(1) << (n - 1)) - SM_MAX_W'(1));
   endfunction

   // Strict a > b; +0 and -0 compare equal.
   function automatic logic sm_gt(input sm_word_t a, input sm_word_t b, input int unsigned n);
      sm_word_t ma;
      sm_word_t mb;
      logic     sa;
      logic     sb;
      ma = sm_mag(a, n);
      mb = sm_mag(b, n);
      sa = sm_sign(a, n);
      sb = sm_sign(b, n);
      if ((ma == '0) && (mb == '0)) return 1'b0;
      if (!sa && sb)                return 1'b1;
      if (sa && !sb)                return 1'b0;
      if (!sa)                      return ma > mb;
      return ma < mb;
   endfunction

endpackage

// File: rtl/sm_minmax_tracker_if.sv
// Sample stream, frame control and result handshake of the min/max tracker.
interface sm_minmax_tracker_if #(
   parameter int unsigned N       = 8,
   parameter int unsigned MAX_LEN = 16
);
   localparam int unsigned LW = $clog2(MAX_LEN + 1);

   logic          in_start;
   logic [LW-1:0] in_len;
   logic [N-1:0]  in_data;
   logic          in_valid;
   logic          o_ready;
   logic [N-1:0]  o_min;
   logic [N-1:0]  o_max;
   logic [LW-1:0] o_min_idx;
   logic [LW-1:0] o_max_idx;
   logic          o_valid;
   logic          in_ready;
   logic          o_busy;

   modport master (
      output in_start, in_len, in_data, in_valid, in_ready,
      input  o_ready, o_min, o_max, o_min_idx, o_max_idx, o_valid, o_busy
   );

   modport slave (
      input  in_start, in_len, in_data, in_valid, in_ready,
      output o_ready, o_min, o_max, o_min_idx, o_max_idx, o_valid, o_busy
   );
endinterface

// File: rtl/sm_compare.sv
// Combinational sign-magnitude comparator: strict greater-than and less-than.
module sm_compare
   import sm_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         o_gt,
   output logic         o_lt
);

   always_comb begin
      o_gt = sm_gt(SM_MAX_W'(a), SM_MAX_W'(b), N);
      o_lt = sm_gt(SM_MAX_W'(b), SM_MAX_W'(a), N);
   end

endmodule

// File: rtl/sm_minmax_tracker.sv
// Frame-based min/max reduction over sign-magnitude samples with index tracking;
// the result is held in DONE until the consumer takes it.
module sm_minmax_tracker
   import sm_pkg::*;
#(
   parameter int unsigned N       = 8,
   parameter int unsigned MAX_LEN = 16
) (
   input logic               clk,
   input logic               rst_n,
   sm_minmax_tracker_if.slave bus
);

   localparam int unsigned LW = $clog2(MAX_LEN + 1);

   state_t        state;
   state_t        state_nxt;
   logic [LW-1:0] len_q;
   logic [LW-1:0] len_nxt;
   logic [LW-1:0] cnt_q;
   logic [LW-1:0] cnt_nxt;
   logic [N-1:0]  min_q;
   logic [N-1:0]  min_nxt;
   logic [N-1:0]  max_q;
   logic [N-1:0]  max_nxt;
   logic [LW-1:0] min_idx_q;
   logic [LW-1:0] min_idx_nxt;
   logic [LW-1:0] max_idx_q;
   logic [LW-1:0] max_idx_nxt;
   logic          ready_q;
   logic          valid_q;
   logic          busy_q;
   logic          gt_max;
   logic          lt_min;
   logic          cmp_max_lt_unused;
   logic          cmp_min_gt_unused;
   logic          accept;

   sm_compare #(.N(N)) u_cmp_max (
      .a    (bus.in_data),
      .b    (max_q),
      .o_gt (gt_max),
      .o_lt (cmp_max_lt_unused)
   );

   sm_compare #(.N(N)) u_cmp_min (
      .a    (bus.in_data),
      .b    (min_q),
      .o_gt (cmp_min_gt_unused),
      .o_lt (lt_min)
   );

   assign accept = (state == RUN) && bus.in_valid;

   // Next-state and datapath update; ties leave the stored pattern and index alone.
   always_comb begin
      state_nxt   = state;
      len_nxt     = len_q;
      cnt_nxt     = cnt_q;
      min_nxt     = min_q;
      max_nxt     = max_q;
      min_idx_nxt = min_idx_q;
      max_idx_nxt = max_idx_q;
      case (state)
         IDLE: begin
            if (bus.in_start && (bus.in_len != '0)) begin
               len_nxt   = (bus.in_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : bus.in_len;
               cnt_nxt   = '0;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (accept) begin
               if (cnt_q == '0) begin
                  min_nxt     = bus.in_data;
                  max_nxt     = bus.in_data;
                  min_idx_nxt = '0;
                  max_idx_nxt = '0;
               end else begin
                  if (gt_max) begin
                     max_nxt     = bus.in_data;
                     max_idx_nxt = cnt_q;
                  end
                  if (lt_min) begin
                     min_nxt     = bus.in_data;
                     min_idx_nxt = cnt_q;
                  end
               end
               cnt_nxt = cnt_q + LW'(1);
               if (cnt_q == (len_q - LW'(1))) state_nxt = DONE;
            end
         end
         DONE: begin
            if (bus.in_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         len_q     <= '0;
         cnt_q     <= '0;
         min_q     <= '0;
         max_q     <= '0;
         min_idx_q <= '0;
         max_idx_q <= '0;
         ready_q   <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         len_q     <= len_nxt;
         cnt_q     <= cnt_nxt;
         min_q     <= min_nxt;
         max_q     <= max_nxt;
         min_idx_q <= min_idx_nxt;
         max_idx_q <= max_idx_nxt;
         ready_q   <= (state_nxt == RUN);
         valid_q   <= (state_nxt == DONE);
         busy_q    <= (state_nxt != IDLE);
      end
   end

   assign bus.o_ready   = ready_q;
   assign bus.o_valid   = valid_q;
   assign bus.o_busy    = busy_q;
   assign bus.o_min     = min_q;
   assign bus.o_max     = max_q;
   assign bus.o_min_idx = min_idx_q;
   assign bus.o_max_idx = max_idx_q;

endmodule

// File: doc/sm_minmax_tracker.md
# sm_minmax_tracker

Streaming min/max finder for N-bit sign-magnitude samples (MSB = sign, remaining bits = magnitude). Over a frame of programmable length it finds the minimum and maximum sample and the index of each. It then presents the result to a downstream consumer through a valid/ready handshake. It extends the team's sign-magnitude ordering rules (+0 equals -0) from a single combinational comparison to a clocked, multi-sample reduction.

## Interface
- N, 8, sample width incl. sign bit (N >= 2)
- MAX_LEN, 16, maximum frame length (>= 1)
- LW, $clog2(MAX_LEN+1), width of length/index fields (derived, not overridden)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- in_start  in  1  frame start request, sampled only in IDLE
- in_len  in  LW  frame length, latched with in_start
- in_data  in  N  sample, sign-magnitude
- in_valid  in  1  in_data valid
- o_ready  out  1  block accepts a sample this cycle
- o_min  out  N  minimum sample of last frame, bit pattern as received
- o_max  out  N  maximum sample of last frame
- o_min_idx  out  LW  0-based index of o_min
- o_max_idx  out  LW  0-based index of o_max
- o_valid  out  1  result valid
- in_ready  in  1  downstream accepts result
- o_busy  out  1  state != IDLE

## Operation
- Ordering: opposite signs -> positive is greater; both positive -> larger magnitude is greater; both negative -> smaller magnitude is greater. Both magnitudes 0 -> equal regardless of sign.
- FSM states: IDLE, RUN, DONE.
- IDLE: o_ready=0, o_valid=0. If in_start=1 and in_len!=0, latch len = min(in_len, MAX_LEN), clear cnt, go to RUN. If in_len==0, in_start is ignored.
- RUN: o_ready=1. A sample is accepted when in_valid & o_ready.
  - cnt==0: min=max=in_data, both idx=0.
  - Otherwise: if sample strictly greater than max, update max and max_idx=cnt. If sample strictly less than min, update min and min_idx=cnt.
  - Ties keep the earlier index and stored pattern.
  - cnt increments on every accept. The accept with cnt==len-1 moves the FSM to DONE.
- DONE: o_valid=1, all result outputs stable. When in_ready=1, go to IDLE. in_start is ignored in RUN and DONE.
- in_data and in_valid are ignored outside RUN.

## Timing
- Reset (async assert): state=IDLE; o_ready, o_valid, o_busy = 0; o_min, o_max, o_min_idx, o_max_idx = 0; cnt=0.
- in_start accepted at edge k -> o_ready=1 from cycle k+1.
- Throughput: 1 sample/cycle. in_valid gaps are allowed; no sample is lost or double-counted.
- Last sample accepted at edge k -> o_valid=1 and results valid in cycle k+1. o_ready=0 from k+1.
- Result handshake at edge j (o_valid & in_ready) -> o_valid=0 in j+1. A new in_start is accepted at the earliest in cycle j+1.
- Results hold their values after leaving DONE until the next frame's first sample overwrites them.
- All outputs are registered. There is no combinational path from in_* to o_*.

## Structure
- Package sm_pkg:
  - state enum (IDLE, RUN, DONE)
  - parametrised sign/magnitude field extraction
  - function sm_gt(a,b) implementing the ordering above with the zero-equality rule
- One sub-module is natural: sm_compare (parameter N), with outputs o_gt and o_lt. Instantiate it twice: sample vs max, and sample vs min.
- Everything else lives in sm_minmax_tracker: FSM, counter, result registers.

## Test plan
- N=8, len=4, samples 0x03,0x85,0x07,0x81 -> o_min=0x85, o_min_idx=1, o_max=0x07, o_max_idx=2; o_valid high the cycle after 4th accept.
- len=3, samples 0x80,0x00,0x80 (±0) -> o_min=o_max=0x80, both idx=0. len=3, samples 0x05,0x05,0x05 -> both idx=0.
- Backpressure: in_ready=0 for 5 cycles in DONE -> outputs constant, o_ready=0, pulsed in_start ignored; in_ready=1 -> o_valid=0 next cycle, o_busy=0.
- Length edges: in_len=0 -> stays IDLE; in_len=1, sample 0xFF -> min=max=0xFF, idx 0; in_len=20 -> exactly 16 samples accepted.
- Gapped stream: len=4, in_valid toggling 1,0,0,1,0,1,1, samples 0x10,0x90,0x7F,0x8F -> 4 accepts, o_min=0x90 idx1, o_max=0x7F idx2.
- rst_n low for 1 cycle mid-RUN after 2 samples -> all outputs 0 immediately. Next frame len=2, samples 0x01,0x02 -> o_min=0x01 idx0, o_max=0x02 idx1, unaffected by the aborted frame.
